// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and bus constants for the oversampled I2C register-file target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  // Level seen on SDA during the acknowledge bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // R/W bit carried in the LSB of the address byte.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Local-side port bundle: write observation strobes and the register read port.
interface i2c_slave_regfile_if #(
  parameter int PTR_W = 4
);
  logic             busy;
  logic             wr_pulse;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             stop_pulse;
  logic [PTR_W-1:0] host_raddr;
  logic [7:0]       host_rdata;

  // The I2C target drives status and read data.
  modport slave (
    output busy, wr_pulse, wr_addr, wr_data, stop_pulse, host_rdata,
    input  host_raddr
  );

  // Local logic watches writes and issues read indices.
  modport master (
    input  busy, wr_pulse, wr_addr, wr_data, stop_pulse, host_rdata,
    output host_raddr
  );
endinterface

// File: rtl/i2c_slave_regfile_bus_sync.sv
// SCL/SDA synchroniser, edge detector and START/STOP detector.
// Events are registered, so pin-to-event latency is SYNC_STAGES+1 clk.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];

  // Synchronise the pins, keep one delayed copy and register the bus events.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      sda_s     <= 1'b1;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d     <= scl_now;
      sda_d     <= sda_now;
      scl_rise  <= scl_now & ~scl_d;
      scl_fall  <= ~scl_now & scl_d;
      sda_s     <= sda_now;
      start_det <= scl_now & scl_d & sda_d & ~sda_now;
      stop_det  <= scl_now & scl_d & ~sda_d & sda_now;
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C target with address match, register pointer and a
// DEPTH-byte auto-incrementing register file readable from local logic.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl,
  inout  wire                  sda,
  i2c_slave_regfile_if.slave   host
);

  localparam int PTR_W = $clog2(DEPTH);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t       state_q, state_n;
  logic [3:0]       bit_cnt_q, bit_cnt_n;
  logic [7:0]       shift_q, shift_n;
  logic [7:0]       tx_q, tx_n;
  logic [PTR_W-1:0] ptr_q, ptr_n;
  logic             rw_q, rw_n;
  logic             drv_q, drv_n;
  logic             busy_q, busy_n;
  logic             wr_pulse_q, wr_pulse_n;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_n;
  logic [7:0]       wr_data_q, wr_data_n;
  logic             stop_pulse_q, stop_pulse_n;
  logic             reg_we;
  logic [7:0]       regs [DEPTH];
  logic [7:0]       rx_byte;
  logic [7:0]       tx_load;
  logic [PTR_W-1:0] ptr_inc;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign tx_load = regs[ptr_q];
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  // Open-drain pin: only ever pulled low, released straight from the reset flop.
  assign sda = drv_q ? 1'b0 : 1'bz;

  assign host.busy       = busy_q;
  assign host.wr_pulse   = wr_pulse_q;
  assign host.wr_addr    = wr_addr_q;
  assign host.wr_data    = wr_data_q;
  assign host.stop_pulse = stop_pulse_q;
  assign host.host_rdata = regs[host.host_raddr];

  // Protocol state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= '0;
      ptr_q        <= '0;
      rw_q         <= RW_WRITE;
      drv_q        <= 1'b0;
      busy_q       <= 1'b0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      stop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      bit_cnt_q    <= bit_cnt_n;
      shift_q      <= shift_n;
      tx_q         <= tx_n;
      ptr_q        <= ptr_n;
      rw_q         <= rw_n;
      drv_q        <= drv_n;
      busy_q       <= busy_n;
      wr_pulse_q   <= wr_pulse_n;
      wr_addr_q    <= wr_addr_n;
      wr_data_q    <= wr_data_n;
      stop_pulse_q <= stop_pulse_n;
    end
  end

  // Register file: cleared on reset, written at the 8th bit of each data byte.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array is reset explicitly because local logic must read zeros after reset.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr_q] <= rx_byte;
    end
  end

  // Next-state and output decode; START/STOP override any bit event.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_n      = state_q;
    bit_cnt_n    = bit_cnt_q;
    shift_n      = shift_q;
    tx_n         = tx_q;
    ptr_n        = ptr_q;
    rw_n         = rw_q;
    drv_n        = drv_q;
    busy_n       = busy_q;
    wr_pulse_n   = 1'b0;
    wr_addr_n    = wr_addr_q;
    wr_data_n    = wr_data_q;
    stop_pulse_n = 1'b0;
    reg_we       = 1'b0;

    if (stop_det) begin
      state_n      = IDLE;
      bit_cnt_n    = '0;
      drv_n        = 1'b0;
      busy_n       = 1'b0;
      stop_pulse_n = 1'b1;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      drv_n     = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt_q + 4'd1;
            if (state_q == WR_DATA && bit_cnt_q == 4'd7) begin
              reg_we     = 1'b1;
              wr_pulse_n = 1'b1;
              wr_addr_n  = ptr_q;
              wr_data_n  = rx_byte;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_n = '0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                drv_n   = 1'b1;
                busy_n  = 1'b1;
                rw_n    = shift_q[0];
                state_n = ADDR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = WAIT_STOP;
              end
            end else if (state_q == PTR) begin
              if ({1'b0, shift_q} < 9'(DEPTH)) begin
                ptr_n   = shift_q[PTR_W-1:0];
                drv_n   = 1'b1;
                state_n = PTR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = WAIT_STOP;
              end
            end else begin
              drv_n   = 1'b1;
              ptr_n   = ptr_inc;
              state_n = WR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q == RW_READ) begin
              tx_n    = tx_load;
              drv_n   = ~tx_load[7];
              state_n = RD_DATA;
            end else begin
              drv_n   = 1'b0;
              state_n = PTR;
            end
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            drv_n   = 1'b0;
            state_n = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_n = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            drv_n     = 1'b0;
            ptr_n     = ptr_inc;
            bit_cnt_n = '0;
            state_n   = RD_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            tx_n  = {tx_q[6:0], 1'b0};
            drv_n = ~tx_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) begin
              bit_cnt_n = 4'd1;
            end else begin
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            tx_n      = tx_load;
            drv_n     = ~tx_load[7];
            bit_cnt_n = '0;
            state_n   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master against the register-file target.
module tb_i2c_slave_regfile;
  import i2c_pkg::*;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic scl_m  = 1'b1;
  logic m_low  = 1'b0;
  wire  sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_regfile_if #(.PTR_W(4)) host_if ();

  i2c_slave_regfile #(
    .SLAVE_ADDR  (7'h50),
    .DEPTH       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .scl  (scl_m),
    .sda  (sda),
    .host (host_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: log writes, count stops, and watch target activity when enabled.
  logic       mon_en   = 1'b0;
  int         low_cnt  = 0;
  int         busy_cnt = 0;
  int         stop_cnt = 0;
  logic [3:0] wa_q [$];
  logic [7:0] wd_q [$];

  always @(negedge clk) begin
    if (host_if.wr_pulse) begin
      wa_q.push_back(host_if.wr_addr);
      wd_q.push_back(host_if.wr_data);
    end
    if (host_if.stop_pulse) stop_cnt++;
    if (!mon_en) begin
      low_cnt  = 0;
      busy_cnt = 0;
    end else begin
      if (sda === 1'b0 && !m_low) low_cnt++;
      if (host_if.busy) busy_cnt++;
    end
  end

  // A quarter SCL period: SCL runs at 1/40 of clk.
  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; q();
    scl_m = 1'b1; q();
    m_low = 1'b1; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_low = 1'b1; q();
    scl_m = 1'b1; q();
    m_low = 1'b0; q();
  endtask

  task automatic clk_bit(input logic b, output logic r);
    m_low = ~b; q();
    scl_m = 1'b1; q();
    r = sda;    q();
    scl_m = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], dummy);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic ack_line);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, b);
      d[i] = b;
    end
    clk_bit(mack, ack_line);
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [7:0] d);
    @(negedge clk);
    host_if.host_raddr = idx;
    #1 d = host_if.host_rdata;
  endtask

  logic       a;
  logic       r;
  logic [7:0] d;
  int         base;
  int         s0;

  initial begin
    host_if.host_raddr = '0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_busy",       32'(host_if.busy),       32'h0);
    check("rst_wr_pulse",   32'(host_if.wr_pulse),   32'h0);
    check("rst_stop_pulse", 32'(host_if.stop_pulse), 32'h0);
    check("rst_wr_addr",    32'(host_if.wr_addr),    32'h0);
    check("rst_wr_data",    32'(host_if.wr_data),    32'h0);
    check("rst_sda",        32'(sda),                32'h1);
    read_reg(4'd0, d);
    check("rst_reg0",       32'(d),                  32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write burst: ptr 3, data 0x11 0x22
    base = wa_q.size();
    s0   = stop_cnt;
    bus_start();
    write_byte(8'hA0, a); check("wb_addr_ack", 32'(a), 32'(ACK));
    write_byte(8'h03, a); check("wb_ptr_ack",  32'(a), 32'(ACK));
    write_byte(8'h11, a); check("wb_d0_ack",   32'(a), 32'(ACK));
    write_byte(8'h22, a); check("wb_d1_ack",   32'(a), 32'(ACK));
    check("wb_busy", 32'(host_if.busy), 32'h1);
    bus_stop();
    q();
    check("wb_wr_count", 32'(wa_q.size() - base), 32'd2);
    if (wa_q.size() >= base + 2) begin
      check("wb_wr0_addr", 32'(wa_q[base]),     32'h3);
      check("wb_wr0_data", 32'(wd_q[base]),     32'h11);
      check("wb_wr1_addr", 32'(wa_q[base + 1]), 32'h4);
      check("wb_wr1_data", 32'(wd_q[base + 1]), 32'h22);
    end
    read_reg(4'd3, d); check("wb_reg3", 32'(d), 32'h11);
    read_reg(4'd4, d); check("wb_reg4", 32'(d), 32'h22);
    check("wb_stop_count", 32'(stop_cnt - s0), 32'd1);
    check("wb_busy_after", 32'(host_if.busy), 32'h0);

    // Random read: set ptr 3, repeated START, read two bytes
    base = wa_q.size();
    bus_start();
    write_byte(8'hA0, a); check("rr_addr_ack", 32'(a), 32'(ACK));
    write_byte(8'h03, a); check("rr_ptr_ack",  32'(a), 32'(ACK));
    bus_start();
    write_byte(8'hA1, a); check("rr_raddr_ack", 32'(a), 32'(ACK));
    read_byte(ACK, d, r);  check("rr_byte0", 32'(d), 32'h11);
    read_byte(NACK, d, r); check("rr_byte1", 32'(d), 32'h22);
    check("rr_nack_bit", 32'(r), 32'h1);
    q();
    check("rr_sda_released", 32'(sda), 32'h1);
    bus_stop();
    check("rr_no_write", 32'(wa_q.size() - base), 32'd0);

    // Address mismatch: 0x51 must be ignored entirely
    base   = wa_q.size();
    mon_en = 1'b1;
    bus_start();
    write_byte(8'hA2, a); check("mm_addr_nack", 32'(a), 32'(NACK));
    write_byte(8'h05, a); check("mm_b1_nack",   32'(a), 32'(NACK));
    write_byte(8'h77, a); check("mm_b2_nack",   32'(a), 32'(NACK));
    bus_stop();
    q();
    check("mm_sda_never_low", 32'(low_cnt),  32'd0);
    check("mm_busy_never",    32'(busy_cnt), 32'd0);
    mon_en = 1'b0;
    check("mm_no_write", 32'(wa_q.size() - base), 32'd0);

    // Wrap: ptr 15, data 0xAA 0xBB lands in reg15 then reg0
    base = wa_q.size();
    bus_start();
    write_byte(8'hA0, a); check("wr_addr_ack", 32'(a), 32'(ACK));
    write_byte(8'h0F, a); check("wr_ptr_ack",  32'(a), 32'(ACK));
    write_byte(8'hAA, a); check("wr_d0_ack",   32'(a), 32'(ACK));
    write_byte(8'hBB, a); check("wr_d1_ack",   32'(a), 32'(ACK));
    bus_stop();
    q();
    check("wr_wr_count", 32'(wa_q.size() - base), 32'd2);
    if (wa_q.size() >= base + 2) begin
      check("wr_wr0_addr", 32'(wa_q[base]),     32'hF);
      check("wr_wr1_addr", 32'(wa_q[base + 1]), 32'h0);
    end
    read_reg(4'd15, d); check("wr_reg15", 32'(d), 32'hAA);
    read_reg(4'd0,  d); check("wr_reg0",  32'(d), 32'hBB);

    // Pointer-only write to 15, then a bad pointer that must not disturb it
    bus_start();
    write_byte(8'hA0, a); check("bp_set_addr_ack", 32'(a), 32'(ACK));
    write_byte(8'h0F, a); check("bp_set_ptr_ack",  32'(a), 32'(ACK));
    bus_stop();
    base = wa_q.size();
    bus_start();
    write_byte(8'hA0, a); check("bp_addr_ack",  32'(a), 32'(ACK));
    write_byte(8'h10, a); check("bp_ptr_nack",  32'(a), 32'(NACK));
    write_byte(8'h55, a); check("bp_data_nack", 32'(a), 32'(NACK));
    bus_stop();
    q();
    check("bp_no_write", 32'(wa_q.size() - base), 32'd0);
    read_reg(4'd0, d); check("bp_reg0", 32'(d), 32'hBB);
    bus_start();
    write_byte(8'hA1, a); check("bp_raddr_ack", 32'(a), 32'(ACK));
    read_byte(NACK, d, r); check("bp_read_ptr15", 32'(d), 32'hAA);
    bus_stop();

    // Reset mid-read while the target drives bit 6 (0) of reg0 = 0xBB
    bus_start();
    write_byte(8'hA0, a); check("rm_addr_ack", 32'(a), 32'(ACK));
    write_byte(8'h00, a); check("rm_ptr_ack",  32'(a), 32'(ACK));
    bus_start();
    write_byte(8'hA1, a); check("rm_raddr_ack", 32'(a), 32'(ACK));
    check("rm_busy_before", 32'(host_if.busy), 32'h1);
    clk_bit(1'b1, r); check("rm_bit7", 32'(r), 32'h1);
    check("rm_target_low", 32'(sda), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm_sda_released", 32'(sda), 32'h1);
    check("rm_busy", 32'(host_if.busy), 32'h0);
    read_reg(4'd0,  d); check("rm_reg0",  32'(d), 32'h0);
    read_reg(4'd15, d); check("rm_reg15", 32'(d), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    bus_start();
    write_byte(8'hA0, a); check("rm_after_ack", 32'(a), 32'(ACK));
    bus_stop();
    q();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Parametrised I2C target running on a system clock. SCL and SDA are oversampled; the block does not use SCL as a clock.
- Adds to the earlier SCL-clocked slave:
  - proper START, repeated-START and STOP detection
  - a configurable 7-bit address match, with NACK on mismatch
  - a register pointer byte
  - a DEPTH-byte register file with auto-increment
  - multi-byte burst reads and writes
- Sits between the board-level I2C pins and local logic. Local logic observes writes and reads registers through a side port.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.
- DEPTH, 16, number of 8-bit registers (2..256).
- PTR_W, $clog2(DEPTH), register pointer width (derived, not overridden).
- SYNC_STAGES, 2, flops in the SCL/SDA synchroniser chain (>=2).

Ports:
- clk  in  1  system clock, >= 16x SCL frequency.
- rst  in  1  asynchronous, active-high reset.
- scl  in  1  I2C clock pin (input only; no clock stretching).
- sda  inout  1  I2C data pin. Open-drain: driven 0 when sda_drv_low, else 'z'.
- busy  out  1  high from an addressed START until STOP or NACKed exit.
- wr_pulse  out  1  one-clk strobe when a data byte is written into the register file.
- wr_addr  out  PTR_W  register index of the write (valid with wr_pulse).
- wr_data  out  8  byte written (valid with wr_pulse).
- stop_pulse  out  1  one-clk strobe on every detected STOP.
- host_raddr  in  PTR_W  local read index.
- host_rdata  out  8  reg[host_raddr], combinational.

Behaviour:
- Reset (async):
  - SDA released; state IDLE; pointer 0; all registers 0.
  - busy, wr_pulse, stop_pulse are 0; wr_addr = 0, wr_data = 0.
  - Reset mid-transfer releases SDA in the same instant.
- Front end:
  - SYNC_STAGES synchroniser on scl/sda, then one register for edge detect. Pin-to-event latency is SYNC_STAGES+1 clk.
  - scl_rise/scl_fall are one-clk pulses.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
  - START/STOP take priority over any data event in the same clk.
- Bit timing:
  - Incoming bits are sampled on scl_rise, MSB first.
  - The target changes SDA only on scl_fall.
  - ACK: drive low from the scl_fall after bit 8 until the next scl_fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - IDLE: START -> ADDR, bit counter = 0.
  - ADDR: shift 8 bits.
    - addr[7:1] == SLAVE_ADDR: go to ADDR_ACK and drive ACK; busy = 1.
    - Otherwise go to WAIT_STOP; SDA stays released (NACK).
  - ADDR_ACK: at the closing scl_fall, R/W=0 -> PTR; R/W=1 -> RD_DATA, first bit reg[ptr][7] placed on SDA at that same fall.
  - PTR: shift 8 bits.
    - Value < DEPTH: load the pointer, ACK, then WR_DATA.
    - Value >= DEPTH: NACK, pointer unchanged, then WAIT_STOP.
  - WR_DATA: after 8 bits, write reg[ptr] and pulse wr_pulse/wr_addr/wr_data on the clk after the 8th scl_rise. ACK, then ptr = (ptr+1) mod DEPTH.
  - WR_ACK: returns to WR_DATA.
  - RD_DATA:
    - Shift reg[ptr] out on successive scl_fall; release SDA for bit 9.
    - ptr increments (mod DEPTH) at the end of the byte.
    - The byte is latched into a shift register at byte start, so a concurrent local change does not tear it.
  - RD_ACK: sample the master bit on scl_rise. 0 (ACK) -> next byte in RD_DATA; 1 (NACK) -> WAIT_STOP, SDA released.
  - WAIT_STOP: ignore bits until STOP or START.
- Transitions valid from any state:
  - START (including repeated START) -> ADDR, SDA released, bit counter cleared, pointer kept.
  - STOP -> IDLE, busy = 0, stop_pulse = 1.
- Wrap-around: pointer DEPTH-1 increments to 0 for both reads and writes.
- A write transaction ending after the pointer byte (no data) only sets the pointer. A following repeated-START read uses it.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (i2c_state_t)
  - the ACK/NACK constants (ACK=1'b0, NACK=1'b1)
  - the RW_WRITE/RW_READ constants
- One sub-module: i2c_bus_sync.
  - Contains the synchroniser, edge detect and START/STOP detector.
  - Outputs scl_rise, scl_fall, sda_s, start_det, stop_det.
- The register file and FSM stay in i2c_slave_regfile.

Test Plan:
- Write burst: START, 0xA0, 0x03, 0x11, 0x22, STOP.
  - All 3 bytes ACKed after the address.
  - wr_pulse twice: (3,0x11) then (4,0x22).
  - host_rdata at 3/4 = 0x11/0x22; stop_pulse once.
- Random read: START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP.
  - SDA returns 0x11 then 0x22; target releases SDA after the NACK.
- Address mismatch: START, 0xA2 (addr 0x51) plus 2 bytes.
  - SDA never driven low; busy stays 0; no wr_pulse.
- Wrap: with DEPTH=16, write ptr 0x0F then 0xAA, 0xBB.
  - reg[15]=0xAA, reg[0]=0xBB.
- Bad pointer: write ptr 0x10 with DEPTH=16.
  - Pointer byte NACKed; pointer and registers unchanged; further bytes ignored until STOP.
- Reset mid-read: assert rst while the target drives a 0 bit.
  - SDA released immediately; busy=0; registers 0.
  - After release, a new START with 0xA0 is ACKed.
